// File: rtl/div_cfg_sched.sv
// Run-time controller for the programmable clock divider: owns the divide ratio and
// high-time, accepts configs over valid/ready, applies them only at period boundaries.
module div_cfg_sched #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEF_PERIOD = 28120,
    parameter int unsigned DEF_HIGH   = 5624
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             applied,
    output logic             clk_out,
    output logic             period_end,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] act_period, act_period_n;
    logic [CNT_W-1:0] act_high, act_high_n;
    logic [CNT_W-1:0] pend_period, pend_period_n;
    logic [CNT_W-1:0] pend_high, pend_high_n;
    logic             pend_v, pend_v_n;
    logic             applied_n, cfg_err_n;
    logic             clk_out_n, period_end_n, running_n;
    logic             last, do_apply, cfg_legal;

    // State and registered outputs; outputs are derived from next-state values so they align with cnt.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            act_period  <= CNT_W'(DEF_PERIOD);
            act_high    <= CNT_W'(DEF_HIGH);
            pend_period <= '0;
            pend_high   <= '0;
            pend_v      <= 1'b0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            applied     <= 1'b0;
            clk_out     <= 1'b0;
            period_end  <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            act_period  <= act_period_n;
            act_high    <= act_high_n;
            pend_period <= pend_period_n;
            pend_high   <= pend_high_n;
            pend_v      <= pend_v_n;
            cfg_ready   <= ~pend_v_n;
            cfg_err     <= cfg_err_n;
            applied     <= applied_n;
            clk_out     <= clk_out_n;
            period_end  <= period_end_n;
            running     <= running_n;
        end
    end

    // Next-state, counter, config handling.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        act_period_n  = act_period;
        act_high_n    = act_high;
        pend_period_n = pend_period;
        pend_high_n   = pend_high;
        pend_v_n      = pend_v;
        applied_n     = 1'b0;
        cfg_err_n     = 1'b0;
        do_apply      = 1'b0;
        last          = (cnt == act_period - CNT_W'(1));
        cfg_legal     = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_period);

        case (state)
            IDLE: begin
                do_apply = pend_v;
                if (en) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN, DRAIN: begin
                if (last) begin
                    cnt_n    = '0;
                    do_apply = pend_v;
                    state_n  = en ? RUN : IDLE;
                end else begin
                    cnt_n   = cnt + CNT_W'(1);
                    state_n = en ? RUN : DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        if (do_apply) begin
            act_period_n = pend_period;
            act_high_n   = pend_high;
            pend_v_n     = 1'b0;
            applied_n    = 1'b1;
        end

        // A transfer can only happen with the slot empty, so it never collides with an apply.
        if (cfg_valid && !pend_v) begin
            if (cfg_legal) begin
                pend_period_n = cfg_period;
                pend_high_n   = cfg_high;
                pend_v_n      = 1'b1;
            end else begin
                cfg_err_n = 1'b1;
            end
        end

        running_n    = (state_n != IDLE);
        clk_out_n    = running_n && (cnt_n < act_high_n);
        period_end_n = running_n && (cnt_n == act_period_n - CNT_W'(1));
    end

endmodule

// File: tb/tb_div_cfg_sched.sv
// Randomised and directed bench for div_cfg_sched: a cycle-level reference model pushes
// expected outputs into a queue that a separate monitor pops and compares.
module tb_div_cfg_sched;

    localparam int unsigned CNT_W  = 16;
    localparam int          DEF_P  = 28120;
    localparam int          DEF_H  = 5624;
    localparam int          TMO    = 70000;

    logic             clk_in = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_high = '0;
    logic             cfg_ready, cfg_err, applied, clk_out, period_end, running;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    // Model state: 0 idle, 1 run, 2 drain; position within the current period.
    int m_st, m_pos, m_aper, m_ahigh, m_pper, m_phigh;
    bit m_pv;
    logic [5:0] exp_q[$];

    div_cfg_sched #(.CNT_W(CNT_W), .DEF_PERIOD(DEF_P), .DEF_HIGH(DEF_H)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .applied    (applied),
        .clk_out    (clk_out),
        .period_end (period_end),
        .running    (running)
    );

    always #5 clk_in = ~clk_in;

    // Expected outputs for the cycle following this edge, from the behavioural rules.
    task automatic model_step();
        logic [5:0] e;
        bit err, appl, accept, active, last;
        int p, h;
        err = 1'b0;
        appl = 1'b0;
        if (rst) begin
            m_st = 0; m_pos = 0; m_aper = DEF_P; m_ahigh = DEF_H; m_pv = 1'b0;
            e = 6'b000100;
        end else begin
            accept = cfg_valid && !m_pv;
            active = (m_st != 0);
            last   = active && (m_pos == m_aper - 1);
            if (m_pv && (!active || last)) begin
                m_aper = m_pper; m_ahigh = m_phigh; m_pv = 1'b0; appl = 1'b1;
            end
            if (accept) begin
                p = int'(cfg_period);
                h = int'(cfg_high);
                if (p >= 2 && h >= 1 && h <= p - 1) begin
                    m_pper = p; m_phigh = h; m_pv = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
            if (!active) begin
                if (en) begin m_st = 1; m_pos = 0; end
            end else if (last) begin
                m_pos = 0; m_st = en ? 1 : 0;
            end else begin
                m_pos = m_pos + 1; m_st = en ? 1 : 2;
            end
            active = (m_st != 0);
            e = {active && (m_pos < m_ahigh), active && (m_pos == m_aper - 1), active,
                 !m_pv, err, appl};
        end
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    // Monitor: compares DUT outputs against the oldest expectation every cycle.
    initial forever begin
        logic [5:0] want, got;
        @(posedge clk_in);
        #1;
        n_cyc++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {clk_out, period_end, running, cfg_ready, cfg_err, applied};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL outputs cyc=%0d {clk_out,period_end,running,cfg_ready,cfg_err,applied} got=%b want=%b",
                             n_cyc, got, want);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send(input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
        @(negedge clk_in);
        cfg_valid  = 1'b0;
    endtask

    // Waits until the divider is running at the given counter position.
    task automatic wait_pos(input int p, input string what);
        int k;
        k = 0;
        while (!((m_st != 0) && (m_pos == p)) && k < TMO) begin
            @(negedge clk_in);
            k++;
        end
        if (k >= TMO) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout %s waited=%0d cycles want pos=%0d", what, k, p);
        end
    endtask

    initial begin
        // Reset with en held, then a full default period plus a little.
        en = 1'b1;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(DEF_P + 200);

        // (10,2) offered with 1000 cycles left in the default period.
        wait_pos(DEF_P - 1000, "mid_period");
        send(10, 2);
        cyc(1100);

        // Illegal configs.
        send(5, 5);  cyc(3);
        send(5, 0);  cyc(3);
        send(1, 0);  cyc(3);

        // (4,1) accepted exactly on a period_end cycle.
        wait_pos(9, "period_end_cfg");
        send(4, 1);
        cyc(40);

        // Back to (10,2), then drop en at cnt=3.
        send(10, 2);
        cyc(12);
        wait_pos(3, "drop_en");
        en = 1'b0;
        cyc(20);
        en = 1'b1;
        cyc(5);
        wait_pos(3, "drop_en2");
        en = 1'b0;
        wait_pos(7, "raise_en");
        en = 1'b1;
        cyc(25);

        // Reset at cnt=1 with a config pending.
        wait_pos(0, "pend_reset");
        send(6, 3);
        rst = 1'b1;
        en  = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(5);

        // Maximum period applied from IDLE with en low, then run a while.
        send(65535, 65534);
        cyc(4);
        en = 1'b1;
        cyc(100);
        en = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        send(7, 3);
        cyc(2);

        // Random traffic with small configs.
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_period = CNT_W'($urandom_range(0, 12));
            cfg_high   = CNT_W'($urandom_range(0, 12));
            @(negedge clk_in);
        end
        rst = 1'b0;
        cfg_valid = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
